// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mux_pkg
// Purpose  : Shared mode encodings, state encodings and the wrap-around
//            "next valid channel" search used by the scanning multiplexer
//            and by future round-robin arbiters.
// Contents : MODE_* encodings, st_t state type, nv_t search result,
//            next_valid() helper.
// Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Mode input encodings; 2'b11 is reserved and decodes as direct.
    localparam logic [1:0] MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MODE_SCAN_ALL = 2'b01;
    localparam logic [1:0] MODE_SCAN_VLD = 2'b10;

    // Widest channel count the shared search supports.
    localparam int MAX_CH = 64;
    localparam int IDX_W  = 6;

    // Mux state encoding.
    typedef logic [1:0] st_t;
    localparam st_t ST_DIRECT   = 2'd0;
    localparam st_t ST_SCAN_ALL = 2'd1;
    localparam st_t ST_SCAN_VLD = 2'd2;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } nv_t;

    // First set bit of vld at or after start, wrapping at n_ch.
    // Walking the offsets from the far end lets the nearest hit win.
    function automatic nv_t next_valid(input logic [MAX_CH-1:0] vld,
                                       input int                n_ch,
                                       input logic [IDX_W-1:0]  start);
        nv_t res;
        int  j;
        res = '0;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < n_ch) begin
                j = int'(start) + k;
                if (j >= n_ch) begin
                    j = j - n_ch;
                end
                if (vld[j[IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_next_vld.sv
`default_nettype none
// ============================================================================
// Module   : rr_next_vld
// Purpose  : Combinational wrap-around priority search: returns the first
//            asserted vld bit at or after start (start, start+1, ..., wrap).
// Ports    : vld   [N_CH-1:0]  request/valid vector
//            start [SEL_W-1:0] search origin (must be < N_CH)
//            found             any bit of vld set
//            idx   [SEL_W-1:0] index of the winning bit (0 when !found)
// Revision : 1.0 - initial release
// ============================================================================
module rr_next_vld
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  vld,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [MAX_CH-1:0] w_vld_ext;
    nv_t               w_res;
    logic              w_unused_idx;

    always_comb begin
        w_vld_ext            = '0;
        w_vld_ext[N_CH-1:0]  = vld;
    end

    assign w_res = next_valid(w_vld_ext, N_CH, IDX_W'(start));

    assign found = w_res.found;
    assign idx   = w_res.idx[SEL_W-1:0];

    // Upper index bits are always zero for narrow channel counts.
    assign w_unused_idx = ^w_res.idx;

endmodule
`default_nettype wire

// File: rtl/mux_nx1_scan.sv
`default_nettype none
// ============================================================================
// Module   : mux_nx1_scan
// Purpose  : Registered N_CH x W multiplexer with direct select, fixed
//            round-robin scan and valid-aware round-robin scan, a
//            valid/ready output handshake and a sticky select-range error.
// Ports    : clk, rst_n          clock, async active-low reset
//            i      [N_CH*W]     packed channel data, channel k at i[k*W +: W]
//            in_vld [N_CH]       per-channel valid
//            mode   [2]          00 direct, 01 scan-all, 10 scan-valid
//            s      [SEL_W]      direct-mode select
//            dwell  [DWELL_W]    extra transfers per channel when scanning
//            y_rdy               downstream ready
//            y, y_ch, y_vld      registered output data, channel, valid
//            err                 sticky: direct select s >= N_CH seen
// Revision : 1.0 - initial release
// ============================================================================
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int N_CH    = 8,
    parameter int W       = 8,
    parameter int DWELL_W = 4,
    parameter int SEL_W   = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH*W-1:0]   i,
    input  logic [N_CH-1:0]     in_vld,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    s,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic                y_rdy,
    output logic [W-1:0]        y,
    output logic [SEL_W-1:0]    y_ch,
    output logic                y_vld,
    output logic                err
);

    localparam logic [SEL_W-1:0] C_LAST = SEL_W'(N_CH - 1);
    localparam logic [SEL_W:0]   C_NCH  = (SEL_W + 1)'(N_CH);

    logic [W-1:0] w_ch [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign w_ch[k] = i[k*W +: W];
    end

    st_t                r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [DWELL_W-1:0] r_dcnt;
    logic [W-1:0]       r_y;
    logic [SEL_W-1:0]   r_y_ch;
    logic               r_y_vld;
    logic               r_err;

    logic               w_load;
    logic               w_xfer;
    logic               w_s_oor;
    st_t                w_nxt_st;
    logic [SEL_W-1:0]   w_cand_ptr;
    logic [DWELL_W-1:0] w_cand_dcnt;
    logic               w_found;
    logic [SEL_W-1:0]   w_idx;
    logic [W-1:0]       w_y;
    logic [SEL_W-1:0]   w_y_ch;
    logic               w_y_vld;
    logic [SEL_W-1:0]   w_ptr;
    logic [DWELL_W-1:0] w_dcnt;
    logic               w_err;

    assign w_load  = !r_y_vld || y_rdy;
    assign w_xfer  = r_y_vld && y_rdy;
    assign w_s_oor = {1'b0, s} >= C_NCH;

    // Target state and the scan position the next load starts from.
    // Entering a scan from direct restarts at channel 0; switching between
    // scan modes keeps the pointer but discards any dwell progress,
    // including the advance that the concurrent transfer would have made.
    always_comb begin
        unique case (mode)
            MODE_SCAN_ALL: w_nxt_st = ST_SCAN_ALL;
            MODE_SCAN_VLD: w_nxt_st = ST_SCAN_VLD;
            default:       w_nxt_st = ST_DIRECT;
        endcase

        w_cand_ptr  = r_ptr;
        w_cand_dcnt = r_dcnt;
        if (r_state == ST_DIRECT) begin
            w_cand_ptr  = '0;
            w_cand_dcnt = '0;
        end else if (w_nxt_st != r_state) begin
            w_cand_dcnt = '0;
        end else if (w_xfer) begin
            if (r_dcnt == dwell) begin
                w_cand_dcnt = '0;
                w_cand_ptr  = (r_ptr == C_LAST) ? '0 : r_ptr + 1'b1;
            end else begin
                w_cand_dcnt = r_dcnt + 1'b1;
            end
        end
    end

    rr_next_vld #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_next_vld (
        .vld   (in_vld),
        .start (w_cand_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_comb begin
        w_y     = '0;
        w_y_ch  = w_cand_ptr;
        w_y_vld = 1'b0;
        w_ptr   = r_ptr;
        w_dcnt  = r_dcnt;
        w_err   = r_err;
        unique case (w_nxt_st)
            ST_SCAN_ALL: begin
                w_y     = w_ch[w_cand_ptr];
                w_y_vld = 1'b1;
                w_ptr   = w_cand_ptr;
                w_dcnt  = w_cand_dcnt;
            end
            ST_SCAN_VLD: begin
                // With nothing valid the (possibly advanced) position is
                // parked and searched again from there on later loads.
                w_ptr  = w_cand_ptr;
                w_dcnt = w_cand_dcnt;
                if (w_found) begin
                    w_y     = w_ch[w_idx];
                    w_y_ch  = w_idx;
                    w_y_vld = 1'b1;
                    w_ptr   = w_idx;
                    // Skipping past the candidate means a fresh channel.
                    if (w_idx != w_cand_ptr) begin
                        w_dcnt = '0;
                    end
                end
            end
            default: begin
                w_y_ch = s;
                if (w_s_oor) begin
                    w_err = 1'b1;
                end else begin
                    w_y     = w_ch[s];
                    w_y_vld = in_vld[s];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_DIRECT;
            r_ptr   <= '0;
            r_dcnt  <= '0;
            r_y     <= '0;
            r_y_ch  <= '0;
            r_y_vld <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            r_state <= w_nxt_st;
            r_ptr   <= w_ptr;
            r_dcnt  <= w_dcnt;
            r_y     <= w_y;
            r_y_ch  <= w_y_ch;
            r_y_vld <= w_y_vld;
            r_err   <= w_err;
        end
    end

    assign y     = r_y;
    assign y_ch  = r_y_ch;
    assign y_vld = r_y_vld;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_nx1_scan
// Purpose  : Self-checking bench for mux_nx1_scan. An 8-channel instance
//            covers direct, scan-all, scan-valid, backpressure, mode switch
//            and reset behaviour; a 6-channel instance covers the select
//            range error. Expected scan order is derived from the transfer
//            count: transfer k shows list[(k / (dwell+1)) % list_len].
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_nx1_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] i;
    logic [7:0]  in_vld;
    logic [1:0]  mode;
    logic [2:0]  s;
    logic [3:0]  dwell;
    logic        y_rdy;
    logic [7:0]  y;
    logic [2:0]  y_ch;
    logic        y_vld;
    logic        err;

    logic        rst6_n;
    logic [47:0] i6;
    logic [5:0]  in_vld6;
    logic [1:0]  mode6;
    logic [2:0]  s6;
    logic [3:0]  dwell6;
    logic        y_rdy6;
    logic [7:0]  y6;
    logic [2:0]  y_ch6;
    logic        y_vld6;
    logic        err6;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  dat [8];

    always #5 clk = ~clk;

    mux_nx1_scan #(.N_CH(8), .W(8), .DWELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .i(i), .in_vld(in_vld), .mode(mode), .s(s),
        .dwell(dwell), .y_rdy(y_rdy), .y(y), .y_ch(y_ch), .y_vld(y_vld), .err(err)
    );

    mux_nx1_scan #(.N_CH(6), .W(8), .DWELL_W(4)) dut6 (
        .clk(clk), .rst_n(rst6_n), .i(i6), .in_vld(in_vld6), .mode(mode6), .s(s6),
        .dwell(dwell6), .y_rdy(y_rdy6), .y(y6), .y_ch(y_ch6), .y_vld(y_vld6), .err(err6)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pack;
        for (int k = 0; k < 8; k++) i[k*8 +: 8] = dat[k];
    endtask

    task automatic rand_data;
        for (int k = 0; k < 8; k++) dat[k] = 8'($urandom);
        pack();
    endtask

    task automatic go_direct;
        mode  = 2'b00;
        y_rdy = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rst6_n = 1'b0;
        i = '0; in_vld = '0; mode = 2'b00; s = '0; dwell = '0; y_rdy = 1'b1;
        i6 = '0; in_vld6 = '0; mode6 = 2'b00; s6 = '0; dwell6 = '0; y_rdy6 = 1'b1;
        #12;
        total++;
        if ({y, y_ch, y_vld, err} !== 13'd0) begin
            bad++;
            $display("FAIL reset8: got y=%h ch=%0d vld=%b err=%b, want all 0", y, y_ch, y_vld, err);
        end
        total++;
        if ({y6, y_ch6, y_vld6, err6} !== 13'd0) begin
            bad++;
            $display("FAIL reset6: got y=%h ch=%0d vld=%b err=%b, want all 0", y6, y_ch6, y_vld6, err6);
        end
        rst_n = 1'b1; rst6_n = 1'b1;
    endtask

    task automatic test_direct;
        logic [2:0] es;
        logic [7:0] ed;
        logic       ev;
        mode = 2'b00; y_rdy = 1'b1; in_vld = 8'hFF;
        for (int k = 0; k < 8; k++) dat[k] = 8'h10 + 8'(k);
        pack();
        for (int k = 0; k < 8; k++) begin
            s = 3'(k);
            tick();
            total++;
            if ({y_vld, y_ch, y, err} !== {1'b1, 3'(k), 8'h10 + 8'(k), 1'b0}) begin
                bad++;
                $display("FAIL direct_sweep s=%0d: got vld=%b ch=%0d y=%h err=%b, want vld=1 ch=%0d y=%h err=0",
                         k, y_vld, y_ch, y, err, k, 8'h10 + 8'(k));
            end
        end
        for (int n = 0; n < 20; n++) begin
            rand_data();
            in_vld = 8'($urandom);
            s      = 3'($urandom);
            es = s; ed = dat[s]; ev = in_vld[s];
            tick();
            total++;
            if ({y_vld, y_ch, y, err} !== {ev, es, ed, 1'b0}) begin
                bad++;
                $display("FAIL direct_rand n=%0d: got vld=%b ch=%0d y=%h err=%b, want vld=%b ch=%0d y=%h err=0",
                         n, y_vld, y_ch, y, err, ev, es, ed);
            end
        end
    endtask

    task automatic test_out_of_range;
        mode6 = 2'b00; y_rdy6 = 1'b1; in_vld6 = 6'h3F;
        for (int k = 0; k < 6; k++) i6[k*8 +: 8] = 8'h20 + 8'(k);
        s6 = 3'd2; tick();
        total++;
        if ({y_vld6, y6, err6} !== {1'b1, 8'h22, 1'b0}) begin
            bad++;
            $display("FAIL oor_pre: got vld=%b y=%h err=%b, want vld=1 y=22 err=0", y_vld6, y6, err6);
        end
        s6 = 3'd7; tick();
        total++;
        if ({y_vld6, y6, err6} !== {1'b0, 8'h00, 1'b1}) begin
            bad++;
            $display("FAIL oor_s7: got vld=%b y=%h err=%b, want vld=0 y=00 err=1", y_vld6, y6, err6);
        end
        s6 = 3'd2; tick();
        total++;
        if ({y_vld6, y6, err6} !== {1'b1, 8'h22, 1'b1}) begin
            bad++;
            $display("FAIL oor_sticky: got vld=%b y=%h err=%b, want vld=1 y=22 err=1", y_vld6, y6, err6);
        end
        s6 = 3'd6; tick();
        total++;
        if ({y_vld6, y6, err6} !== {1'b0, 8'h00, 1'b1}) begin
            bad++;
            $display("FAIL oor_s6: got vld=%b y=%h err=%b, want vld=0 y=00 err=1", y_vld6, y6, err6);
        end
        rst6_n = 1'b0; #2;
        total++;
        if ({y6, y_ch6, y_vld6, err6} !== 13'd0) begin
            bad++;
            $display("FAIL oor_reset: got y=%h ch=%0d vld=%b err=%b, want all 0", y6, y_ch6, y_vld6, err6);
        end
        rst6_n = 1'b1;
        s6 = 3'd5; tick();
        total++;
        if ({y_vld6, y_ch6, y6, err6} !== {1'b1, 3'd5, 8'h25, 1'b0}) begin
            bad++;
            $display("FAIL oor_last: got vld=%b ch=%0d y=%h err=%b, want vld=1 ch=5 y=25 err=0",
                     y_vld6, y_ch6, y6, err6);
        end
    endtask

    // Scan from channel 0 with random ready; the expected channel follows
    // from how many transfers have completed.
    task automatic run_scan(input string tag, input int q[$], input int dw, input int cycles);
        int k;
        int ch;
        logic xfer;
        k = 0;
        tick();
        for (int n = 0; n <= cycles; n++) begin
            if (n > 0) begin
                y_rdy = 1'($urandom_range(0, 1));
                xfer  = y_rdy;
                tick();
                if (xfer) k++;
            end
            ch = q[(k / (dw + 1)) % q.size()];
            total++;
            if ({y_vld, y_ch, y} !== {1'b1, 3'(ch), dat[ch]}) begin
                bad++;
                $display("FAIL %s dw=%0d k=%0d: got vld=%b ch=%0d y=%h, want vld=1 ch=%0d y=%h",
                         tag, dw, k, y_vld, y_ch, y, ch, dat[ch]);
            end
        end
        y_rdy = 1'b1;
    endtask

    task automatic test_scan_all;
        int ch;
        go_direct();
        dwell = 4'd1; in_vld = 8'h00; rand_data();
        mode = 2'b01; y_rdy = 1'b1;
        for (int k = 0; k < 18; k++) begin
            tick();
            ch = (k / 2) % 8;
            total++;
            if ({y_vld, y_ch, y} !== {1'b1, 3'(ch), dat[ch]}) begin
                bad++;
                $display("FAIL scan_all k=%0d: got vld=%b ch=%0d y=%h, want vld=1 ch=%0d y=%h",
                         k, y_vld, y_ch, y, ch, dat[ch]);
            end
        end
    endtask

    task automatic test_backpressure;
        int q[$];
        int ch;
        int k;
        go_direct();
        dwell = 4'd1; rand_data(); mode = 2'b01; y_rdy = 1'b1;
        k = 0;
        tick();
        while (k < 6) begin tick(); k++; end
        y_rdy = 1'b0;
        for (int n = 0; n < 7; n++) begin
            if (n == 5) y_rdy = 1'b1;
            if (n >= 5) begin
                tick(); k++;
            end else begin
                tick();
            end
            ch = (k / 2) % 8;
            total++;
            if ({y_vld, y_ch, y} !== {1'b1, 3'(ch), dat[ch]}) begin
                bad++;
                $display("FAIL stall n=%0d: got vld=%b ch=%0d y=%h, want vld=1 ch=%0d y=%h",
                         n, y_vld, y_ch, y, ch, dat[ch]);
            end
        end
        for (int c = 0; c < 8; c++) q.push_back(c);
        for (int dw = 0; dw < 4; dw++) begin
            go_direct();
            dwell = 4'(dw); rand_data(); in_vld = 8'($urandom); mode = 2'b01;
            run_scan("scan_all_rand", q, dw, 40);
        end
    endtask

    task automatic test_scan_valid;
        int q[$];
        int exp_ch [5] = '{2, 5, 7, 2, 5};
        int dw;
        go_direct();
        dwell = 4'd0; in_vld = 8'b1010_0100; rand_data(); mode = 2'b10; y_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if ({y_vld, y_ch, y} !== {1'b1, 3'(exp_ch[k]), dat[exp_ch[k]]}) begin
                bad++;
                $display("FAIL scan_vld k=%0d: got vld=%b ch=%0d y=%h, want vld=1 ch=%0d y=%h",
                         k, y_vld, y_ch, y, exp_ch[k], dat[exp_ch[k]]);
            end
        end
        in_vld = 8'h00;
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if (y_vld !== 1'b0) begin
                bad++;
                $display("FAIL scan_vld_none n=%0d: got vld=%b, want vld=0", n, y_vld);
            end
        end
        in_vld = 8'b0100_0001;
        tick();
        total++;
        if ({y_vld, y_ch, y} !== {1'b1, 3'd6, dat[6]}) begin
            bad++;
            $display("FAIL scan_vld_resume: got vld=%b ch=%0d y=%h, want vld=1 ch=6 y=%h",
                     y_vld, y_ch, y, dat[6]);
        end
        tick();
        total++;
        if ({y_vld, y_ch, y} !== {1'b1, 3'd0, dat[0]}) begin
            bad++;
            $display("FAIL scan_vld_wrap: got vld=%b ch=%0d y=%h, want vld=1 ch=0 y=%h",
                     y_vld, y_ch, y, dat[0]);
        end
        for (int r = 0; r < 3; r++) begin
            go_direct();
            dw = $urandom_range(0, 2);
            dwell = 4'(dw); rand_data();
            do in_vld = 8'($urandom); while (in_vld == 8'h00);
            q.delete();
            for (int c = 0; c < 8; c++) if (in_vld[c]) q.push_back(c);
            mode = 2'b10;
            run_scan("scan_vld_rand", q, dw, 40);
        end
    endtask

    task automatic test_mode_switch;
        int exp_ch [5] = '{2, 2, 2, 2, 3};
        go_direct();
        dwell = 4'd3; in_vld = 8'hFF; rand_data(); mode = 2'b01; y_rdy = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        total++;
        if ({y_vld, y_ch} !== {1'b1, 3'd2}) begin
            bad++;
            $display("FAIL switch_pre: got vld=%b ch=%0d, want vld=1 ch=2", y_vld, y_ch);
        end
        mode = 2'b10;
        for (int n = 0; n < 5; n++) begin
            tick();
            total++;
            if ({y_vld, y_ch, y} !== {1'b1, 3'(exp_ch[n]), dat[exp_ch[n]]}) begin
                bad++;
                $display("FAIL switch n=%0d: got vld=%b ch=%0d y=%h, want vld=1 ch=%0d y=%h",
                         n, y_vld, y_ch, y, exp_ch[n], dat[exp_ch[n]]);
            end
        end
    endtask

    task automatic test_reset_mid_stall;
        go_direct();
        dwell = 4'd0; rand_data(); mode = 2'b01; y_rdy = 1'b1;
        tick(); tick();
        y_rdy = 1'b0;
        tick(); tick();
        total++;
        if ({y_vld, y_ch, y} !== {1'b1, 3'd1, dat[1]}) begin
            bad++;
            $display("FAIL pre_reset_stall: got vld=%b ch=%0d y=%h, want vld=1 ch=1 y=%h",
                     y_vld, y_ch, y, dat[1]);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({y, y_ch, y_vld, err} !== 13'd0) begin
            bad++;
            $display("FAIL reset_mid_stall: got y=%h ch=%0d vld=%b err=%b, want all 0", y, y_ch, y_vld, err);
        end
        #2;
        rst_n = 1'b1;
        y_rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if ({y_vld, y_ch, y, err} !== {1'b1, 3'(k), dat[k], 1'b0}) begin
                bad++;
                $display("FAIL post_reset k=%0d: got vld=%b ch=%0d y=%h err=%b, want vld=1 ch=%0d y=%h err=0",
                         k, y_vld, y_ch, y, err, k, dat[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_out_of_range();
        test_scan_all();
        test_backpressure();
        test_scan_valid();
        test_mode_switch();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
